led_rate_gen: RTL

//  Multi-channel LED pattern generator. The next generation of the switch-rate

---
 rtl/led_rate_gen_pkg.sv | 21 ++
 rtl/led_rate_chan.sv | 90 +++++++++
 rtl/led_rate_gen.sv | 76 +++++++
 3 files changed

// File: rtl/led_rate_gen_pkg.sv
// ============================================================================
// led_rate_gen_pkg : shared modes and config FSM encoding for led_rate_gen
// Rev 1.0
// ============================================================================
`default_nettype none

package led_rate_gen_pkg;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_BLINK   = 2'd1;
  localparam logic [1:0] MODE_DIM     = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  typedef enum logic [0:0] {
    ST_READY = 1'b0,
    ST_HOLD  = 1'b1
  } cfg_state_e;

endpackage

`default_nettype wire

// File: rtl/led_rate_chan.sv
// ============================================================================
// led_rate_chan : one LED channel (step/mode/phase accumulator + output mux)
// Optional BREATHE triangle output under LED_RATE_GEN_BREATHE_EN. Rev 1.0
// ============================================================================
`default_nettype none

module led_rate_chan
  import led_rate_gen_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int STEP_W = 8,
  parameter int PWM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              load,
  input  logic [STEP_W-1:0] load_step,
  input  logic [1:0]        load_mode,
  input  logic [PWM_W-1:0]  pwm_cnt,
  output logic              led
);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [1:0]        mode_q, mode_d;
  logic              led_q, led_d;
  logic [PWM_W-1:0]  dim_duty;
  logic              breathe_led;

  assign dim_duty = step_q[STEP_W-1 -: PWM_W];

`ifdef LED_RATE_GEN_BREATHE_EN
  logic [PWM_W:0]   tri_t;
  logic [PWM_W-1:0] tri_duty;

  // MSB-aligned phase slice; short accumulators are padded with zeros below.
  if (ACC_W >= PWM_W + 1) begin : g_tri_wide
    assign tri_t = acc_q[ACC_W-1 -: PWM_W+1];
  end else begin : g_tri_narrow
    assign tri_t = {acc_q, {(PWM_W+1-ACC_W){1'b0}}};
  end

  assign tri_duty    = tri_t[PWM_W] ? ~tri_t[PWM_W-1:0] : tri_t[PWM_W-1:0];
  assign breathe_led = (pwm_cnt < tri_duty);
`else
  assign breathe_led = acc_q[ACC_W-1];
`endif

  always_comb begin
    acc_d  = acc_q;
    step_d = step_q;
    mode_d = mode_q;
    led_d  = led_q;
    if (run) begin
      acc_d = acc_q + ACC_W'(step_q);
      case (mode_q)
        MODE_OFF:   led_d = 1'b0;
        MODE_BLINK: led_d = acc_q[ACC_W-1];
        MODE_DIM:   led_d = (pwm_cnt < dim_duty);
        default:    led_d = breathe_led;
      endcase
    end
    // A config load restarts the phase and wins over the run increment.
    if (load) begin
      acc_d  = '0;
      step_d = load_step;
      mode_d = load_mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      step_q <= '0;
      mode_q <= MODE_OFF;
      led_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      step_q <= step_d;
      mode_q <= mode_d;
      led_q  <= led_d;
    end
  end

  assign led = led_q;

endmodule

`default_nettype wire

// File: rtl/led_rate_gen.sv
// ============================================================================
// led_rate_gen : multi-channel LED pattern generator with valid/ready config
// Build option LED_RATE_GEN_BREATHE_EN enables mode 3 (BREATHE). Rev 1.0
// ============================================================================
`default_nettype none

module led_rate_gen
  import led_rate_gen_pkg::*;
#(
  parameter int CH     = 8,
  parameter int ACC_W  = 32,
  parameter int STEP_W = 8,
  parameter int PWM_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [$clog2(CH)-1:0] cfg_ch,
  input  logic [STEP_W-1:0]     cfg_step,
  input  logic [1:0]            cfg_mode,
  output logic [CH-1:0]         led
);

  localparam int CH_W = $clog2(CH);

  cfg_state_e       state_q, state_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             accept;

  assign cfg_ready = (state_q == ST_READY);
  assign accept    = cfg_valid && cfg_ready;

  always_comb begin
    state_d   = state_q;
    pwm_cnt_d = pwm_cnt_q;
    case (state_q)
      ST_READY: if (accept) state_d = ST_HOLD;
      ST_HOLD:  state_d = ST_READY;
      default:  state_d = ST_READY;
    endcase
    if (run) pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_READY;
      pwm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  // Channel indices at or above CH decode to no strobe: handshake only.
  for (genvar i = 0; i < CH; i++) begin : g_chan
    led_rate_chan #(
      .ACC_W  (ACC_W),
      .STEP_W (STEP_W),
      .PWM_W  (PWM_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .load      (accept && (cfg_ch == CH_W'(i))),
      .load_step (cfg_step),
      .load_mode (cfg_mode),
      .pwm_cnt   (pwm_cnt_q),
      .led       (led[i])
    );
  end

endmodule

`default_nettype wire
